// File: rtl/spi_pixel_writer.sv
// -----------------------------------------------------------------------------
// spi_pixel_writer
//
// Receives 24-bit command frames over a mode-0 SPI link (MSB first) and turns
// them into single-pixel frame-buffer write requests on the MainClk domain.
//
// Frame layout: [23:22] opcode, [21:19] ignored, [18:0] payload
//   00 SET_ADDR : current address <= payload
//   01 WRITE    : issue write of payload[7:0] at current address, then
//                 post-increment the address (modulo 2^ADDR_W)
//   1x          : reserved, discarded
//
// Ports
//   MainClk  in   system clock, every register lives here
//   Reset    in   asynchronous active-high reset
//   Sclk     in   SPI clock (asynchronous, synchronized internally)
//   Mosi     in   SPI data (asynchronous, synchronized internally)
//   CSel     in   SPI chip select, active low (synchronized internally)
//   WrAddr   out  address of the pending write
//   WrData   out  pixel byte of the pending write
//   WrReq    out  high while a write is pending
//   WrAck    in   one-cycle pulse: pending write consumed
//   Overrun  out  sticky: a WRITE frame was dropped because one was pending
// -----------------------------------------------------------------------------
module spi_pixel_writer #(
    parameter int ADDR_W      = 19,
    parameter int SYNC_STAGES = 2
) (
    input  logic              MainClk,
    input  logic              Reset,
    input  logic              Sclk,
    input  logic              Mosi,
    input  logic              CSel,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [7:0]        WrData,
    output logic              WrReq,
    input  logic              WrAck,
    output logic              Overrun
);

    localparam logic [1:0] OP_SET_ADDR = 2'b00;
    localparam logic [1:0] OP_WRITE    = 2'b01;
    localparam logic [4:0] LAST_BIT    = 5'd23;

    // -------------------------------------------------------------------------
    // Input synchronizers. Each chain is {flops, raw input}; the flops take the
    // low SYNC_STAGES bits (a one-place shift) and the top bit is the
    // synchronized output. This form also holds for SYNC_STAGES == 1.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csel_sync_q;
    logic [SYNC_STAGES:0]   sclk_chain, mosi_chain, csel_chain;
    logic                   sclk_s, mosi_s, csel_s;
    logic                   sclk_dly_q;
    logic                   sclk_rise;

    assign sclk_chain = {sclk_sync_q, Sclk};
    assign mosi_chain = {mosi_sync_q, Mosi};
    assign csel_chain = {csel_sync_q, CSel};

    assign sclk_s = sclk_chain[SYNC_STAGES];
    assign mosi_s = mosi_chain[SYNC_STAGES];
    assign csel_s = csel_chain[SYNC_STAGES];

    always_ff @(posedge MainClk or posedge Reset) begin
        if (Reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            // Preset to deselected so reset release never looks like a
            // falling chip select.
            csel_sync_q <= '1;
            sclk_dly_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_chain[SYNC_STAGES-1:0];
            mosi_sync_q <= mosi_chain[SYNC_STAGES-1:0];
            csel_sync_q <= csel_chain[SYNC_STAGES-1:0];
            sclk_dly_q  <= sclk_s;
        end
    end

    // Sclk and Mosi see identical synchronizer delay, so the Mosi value seen
    // alongside the detected edge is the one the master presented at the edge.
    assign sclk_rise = sclk_s & ~sclk_dly_q;

    // -------------------------------------------------------------------------
    // Frame deserializer
    // -------------------------------------------------------------------------
    logic [23:0] frame_q, frame_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        frame_done_q, frame_done_d;

    always_comb begin
        frame_d      = frame_q;
        bit_cnt_d    = bit_cnt_q;
        frame_done_d = 1'b0;
        if (csel_s) begin
            // Deselect drops any partial frame; the shift register contents
            // are irrelevant since only a full 24-bit frame is ever decoded.
            bit_cnt_d = '0;
        end else if (sclk_rise) begin
            frame_d = {frame_q[22:0], mosi_s};
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d    = '0;
                frame_done_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge MainClk or posedge Reset) begin
        if (Reset) begin
            frame_q      <= '0;
            bit_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_q      <= frame_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Decode and write-request handshake. frame_done_q marks the decode cycle;
    // Sclk phases of >= 3 MainClk guarantee frame_q is still intact here.
    // -------------------------------------------------------------------------
    logic [1:0]        opcode;
    logic [ADDR_W-1:0] payload;

    assign opcode  = frame_q[23:22];
    assign payload = ADDR_W'(frame_q[18:0]);

    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              wr_req_q, wr_req_d;
    logic              overrun_q, overrun_d;
    logic              slot_free;

    // The pending slot can take a new write if empty or being acked right now.
    assign slot_free = ~wr_req_q | WrAck;

    always_comb begin
        cur_addr_d = cur_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_req_d   = wr_req_q;
        overrun_d  = overrun_q;

        if (wr_req_q && WrAck) begin
            wr_req_d = 1'b0;
        end

        if (frame_done_q) begin
            case (opcode)
                OP_SET_ADDR: begin
                    cur_addr_d = payload;
                end
                OP_WRITE: begin
                    if (slot_free) begin
                        wr_addr_d  = cur_addr_q;
                        wr_data_d  = frame_q[7:0];
                        wr_req_d   = 1'b1;
                        cur_addr_d = cur_addr_q + ADDR_W'(1);
                    end else begin
                        // Dropped write leaves the address where it was so the
                        // host can tell exactly which pixel was lost.
                        overrun_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge MainClk or posedge Reset) begin
        if (Reset) begin
            cur_addr_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_req_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            cur_addr_q <= cur_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_req_q   <= wr_req_d;
            overrun_q  <= overrun_d;
        end
    end

    assign WrAddr  = wr_addr_q;
    assign WrData  = wr_data_q;
    assign WrReq   = wr_req_q;
    assign Overrun = overrun_q;

endmodule
